// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: shared FSM state type, scan length limit and per-state TMS values for the JTAG shift sequencer
// Macro JTAG_SEQ_TLR_EN adds the TLR state used for Test-Logic-Reset recovery.
package jtag_seq_pkg;

    localparam int MAX_LEN = 32;
    localparam int TLR_LEN = 6;

    // Each scan state names the TAP state the target occupies during that TCK period.
    // ERR is the two-cycle turnaround for an illegal length; it never toggles tck.
    typedef enum logic [3:0] {
        IDLE,
        RTI,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE,
`ifdef JTAG_SEQ_TLR_EN
        TLR,
`endif
        ERR
    } state_t;

    // TMS presented during a period steers the TAP at the rising tck of that period.
    localparam logic TMS_RTI        = 1'b1;
    localparam logic TMS_SEL_DR_DR  = 1'b0;
    localparam logic TMS_SEL_DR_IR  = 1'b1;
    localparam logic TMS_SEL_IR     = 1'b0;
    localparam logic TMS_CAPTURE    = 1'b0;
    localparam logic TMS_SHIFT      = 1'b0;
    localparam logic TMS_SHIFT_LAST = 1'b1;
    localparam logic TMS_EXIT1      = 1'b1;
    localparam logic TMS_UPDATE     = 1'b0;
    localparam logic TMS_IDLE       = 1'b0;
`ifdef JTAG_SEQ_TLR_EN
    localparam logic TMS_TLR        = 1'b1;
    localparam logic TMS_TLR_LAST   = 1'b0;
`endif

    function automatic logic tms_of(input state_t s, input logic ir, input logic last);
        case (s)
            RTI:     return TMS_RTI;
            SEL_DR:  return ir ? TMS_SEL_DR_IR : TMS_SEL_DR_DR;
            SEL_IR:  return TMS_SEL_IR;
            CAPTURE: return TMS_CAPTURE;
            SHIFT:   return last ? TMS_SHIFT_LAST : TMS_SHIFT;
            EXIT1:   return TMS_EXIT1;
            UPDATE:  return TMS_UPDATE;
`ifdef JTAG_SEQ_TLR_EN
            TLR:     return last ? TMS_TLR_LAST : TMS_TLR;
`endif
            default: return TMS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider, TCK_DIV clk cycles low then TCK_DIV high while run is set
// Ports: clk, rst (async, active high), run (enable), tck (registered test clock),
//        rise_stb / fall_stb (high in the cycle whose closing clk edge raises / lowers tck).
module jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    logic [7:0] cnt;
    logic       flip;

    assign flip     = run && cnt == 8'(TCK_DIV - 1);
    assign rise_stb = flip && !tck;
    assign fall_stb = flip && tck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (flip) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/jtag_shift_sequencer.sv
// jtag_shift_sequencer: runs one IR or DR scan per command from Run-Test/Idle and returns captured TDO
// Ports: clk, rst (async, active high); cmd_valid/cmd_ready handshake with cmd_ir, cmd_len, cmd_data;
//        rsp_valid pulse with rsp_err, rsp_data; busy; JTAG pins tck, tms, tdi, tdo.
// Macro JTAG_SEQ_TLR_EN adds cmd_tlr: five TMS-high periods then one low, landing in Run-Test/Idle.
module jtag_shift_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_ir,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
`ifdef JTAG_SEQ_TLR_EN
    input  logic        cmd_tlr,
`endif
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    state_t      state;
    logic        ir_r;
    logic [5:0]  len_r;
    logic [31:0] data_r;
    logic [31:0] cap;
    logic [5:0]  bit_cnt;
    logic        run;
    logic        rise_stb;
    logic        fall_stb;
    logic        done;
    logic        bad_len;

    assign busy    = ~cmd_ready;
    assign run     = state != IDLE && state != ERR;
    assign bad_len = cmd_len == 6'd0 || cmd_len > 6'(MAX_LEN);

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .tck      (tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // ERR finishes on its second cycle (bit_cnt doubles as the delay counter).
    always_comb begin
        done = (state == ERR && bit_cnt[0]) || (fall_stb && state == UPDATE);
`ifdef JTAG_SEQ_TLR_EN
        if (fall_stb && state == TLR && bit_cnt == 6'(TLR_LEN - 1)) done = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ir_r      <= 1'b0;
            len_r     <= '0;
            data_r    <= '0;
            cap       <= '0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            tms       <= 1'b0;
            tdi       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                ir_r      <= cmd_ir;
                len_r     <= cmd_len;
                data_r    <= cmd_data;
                cap       <= '0;
                bit_cnt   <= '0;
                cmd_ready <= 1'b0;
`ifdef JTAG_SEQ_TLR_EN
                if (cmd_tlr) begin
                    state <= TLR;
                    tms   <= tms_of(TLR, 1'b0, 1'b0);
                end else
`endif
                if (bad_len) begin
                    state <= ERR;
                end else begin
                    state <= RTI;
                    tms   <= tms_of(RTI, cmd_ir, 1'b0);
                end
            end else if (done) begin
                state     <= IDLE;
                cmd_ready <= 1'b1;
                rsp_valid <= 1'b1;
                rsp_err   <= state == ERR;
                rsp_data  <= cap;
                tms       <= 1'b0;
                tdi       <= 1'b0;
            end else if (state == ERR) begin
                bit_cnt <= 6'd1;
            end else begin
                if (rise_stb && state == SHIFT) cap[bit_cnt[4:0]] <= tdo;
                if (fall_stb) begin
                    case (state)
                        RTI: begin
                            state <= SEL_DR;
                            tms   <= tms_of(SEL_DR, ir_r, 1'b0);
                        end
                        SEL_DR: begin
                            state <= ir_r ? SEL_IR : CAPTURE;
                            tms   <= ir_r ? tms_of(SEL_IR, ir_r, 1'b0) : tms_of(CAPTURE, ir_r, 1'b0);
                        end
                        SEL_IR: begin
                            state <= CAPTURE;
                            tms   <= tms_of(CAPTURE, ir_r, 1'b0);
                        end
                        CAPTURE: begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                            tdi     <= data_r[0];
                            tms     <= tms_of(SHIFT, ir_r, len_r == 6'd1);
                        end
                        SHIFT: begin
                            if (bit_cnt == len_r - 6'd1) begin
                                state <= EXIT1;
                                tdi   <= 1'b0;
                                tms   <= tms_of(EXIT1, ir_r, 1'b0);
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                tdi     <= data_r[bit_cnt[4:0] + 5'd1];
                                tms     <= tms_of(SHIFT, ir_r, bit_cnt + 6'd2 == len_r);
                            end
                        end
                        EXIT1: begin
                            state <= UPDATE;
                            tms   <= tms_of(UPDATE, ir_r, 1'b0);
                        end
`ifdef JTAG_SEQ_TLR_EN
                        TLR: begin
                            bit_cnt <= bit_cnt + 6'd1;
                            tms     <= tms_of(TLR, 1'b0, bit_cnt == 6'(TLR_LEN - 2));
                        end
`endif
                        default: state <= state;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// tb_jtag_shift_sequencer: directed table-driven bench for jtag_shift_sequencer with TCK_DIV=2
module tb_jtag_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_ir = 1'b0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
`ifdef JTAG_SEQ_TLR_EN
    logic        cmd_tlr = 1'b0;
`endif
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic [1:0]  tdo_mode = 2'd0;

    int checks = 0;
    int errors = 0;

    // Target model: mode 0 loops tdi back, mode 1 holds tdo high, mode 2 holds it low.
    assign tdo = tdo_mode == 2'd0 ? tdi : tdo_mode == 2'd1;

    always #5 clk = ~clk;

    jtag_shift_sequencer #(.TCK_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
`ifdef JTAG_SEQ_TLR_EN
        .cmd_tlr   (cmd_tlr),
`endif
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    typedef struct {
        logic        ir;
        logic [5:0]  len;
        logic [31:0] data;
        logic [1:0]  mode;
        logic [31:0] exp_data;
        logic        exp_err;
        int          lat;
        int          rises;
        logic [63:0] tms;
    } vec_t;

    vec_t vec [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer a command at idle; it is taken on the next posedge, after which the inputs are scrambled.
    task automatic issue(input logic ir, input logic [5:0] len, input logic [31:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_ir    = ~ir;
        cmd_len   = 6'd7;
        cmd_data  = $urandom;
    endtask

    // k counts clk edges after acceptance; tms is recorded at every tck rise.
    task automatic collect(output int lat, output int rises, output logic [63:0] seq);
        logic prev;
        lat   = -1;
        rises = 0;
        seq   = '0;
        prev  = tck;
        for (int k = 0; k < 400 && lat < 0; k++) begin
            @(negedge clk);
            if (tck && !prev) begin
                if (rises < 64) seq[rises] = tms;
                rises++;
            end
            prev = tck;
            if (k == 1) check("busy_during_cmd", {busy, cmd_ready}, 2'b10);
            if (rsp_valid) lat = k;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 400 cycles");
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        int          rises;
        logic [63:0] seq;
        tdo_mode = v.mode;
        issue(v.ir, v.len, v.data);
        collect(lat, rises, seq);
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        check({tag, "_tck_rises"}, 64'(rises), 64'(v.rises));
        check({tag, "_tms_seq"}, seq, v.tms);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        check({tag, "_ready_at_rsp"}, {cmd_ready, busy}, 2'b10);
        @(negedge clk);
        check({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_hold"}, {rsp_err, rsp_data}, {v.exp_err, v.exp_data});
    endtask

    initial begin
        int          lat;
        int          rises;
        logic [63:0] seq;
        //          ir    len     data           mode  exp_data       err   lat  rises tms
        vec[0]  = '{1'b0, 6'd8,  32'h000000A5, 2'd0, 32'h000000A5, 1'b0, 52,  13, 64'h0C01};
        vec[1]  = '{1'b1, 6'd4,  32'h0000000E, 2'd1, 32'h0000000F, 1'b0, 40,  10, 64'h0183};
        vec[2]  = '{1'b0, 6'd0,  32'h12345678, 2'd1, 32'h00000000, 1'b1, 2,   0,  64'h0};
        vec[3]  = '{1'b0, 6'd40, 32'hFFFFFFFF, 2'd1, 32'h00000000, 1'b1, 2,   0,  64'h0};
        vec[4]  = '{1'b0, 6'd32, 32'hDEADBEEF, 2'd0, 32'hDEADBEEF, 1'b0, 148, 37, 64'h0000000C00000001};
        vec[5]  = '{1'b0, 6'd1,  32'h00000001, 2'd0, 32'h00000001, 1'b0, 24,  6,  64'h19};
        vec[6]  = '{1'b1, 6'd33, 32'hFFFFFFFF, 2'd1, 32'h00000000, 1'b1, 2,   0,  64'h0};
        vec[7]  = '{1'b1, 6'd8,  32'h0000003C, 2'd2, 32'h00000000, 1'b0, 56,  14, 64'h1803};
        vec[8]  = '{1'b1, 6'd1,  32'h00000000, 2'd2, 32'h00000000, 1'b0, 28,  7,  64'h33};
        vec[9]  = '{1'b0, 6'd12, 32'hFFFFF123, 2'd0, 32'h00000123, 1'b0, 68,  17, 64'hC001};
        vec[10] = '{1'b1, 6'd32, 32'h00000000, 2'd1, 32'hFFFFFFFF, 1'b0, 152, 38, 64'h0000001800000003};

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {tck, tms, tdi, cmd_ready, busy, rsp_valid, rsp_err}, 7'b0001000);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {tck, cmd_ready, busy}, 3'b010);

        for (int i = 0; i < 11; i++) run_vec(vec[i], $sformatf("v%0d", i));

        // Reset during shift bit 3 (TCK period 6) of a DR scan of 0x5A.
        tdo_mode = 2'd0;
        issue(1'b0, 6'd8, 32'h0000005A);
        repeat (26) @(negedge clk);
        check("pre_reset_state", {busy, tck, tdi}, 3'b101);
        rst = 1'b1;
        #1;
        check("midscan_reset_outputs", {tck, tms, tdi, cmd_ready, busy, rsp_valid, rsp_err}, 7'b0001000);
        check("midscan_reset_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vec[0], "after_reset");

        // cmd_valid held through a scan: the second command is taken only once cmd_ready returns.
        tdo_mode = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = 1'b0;
        cmd_len   = 6'd8;
        cmd_data  = 32'h000000C3;
        @(posedge clk);
        #1;
        cmd_len  = 6'd0;
        cmd_data = 32'hFFFFFFFF;
        collect(lat, rises, seq);
        check("held_first_latency", 64'(lat), 64'd52);
        check("held_first_data", {rsp_err, rsp_data}, {1'b0, 32'h000000C3});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        collect(lat, rises, seq);
        check("held_second_latency", 64'(lat), 64'd2);
        check("held_second_err", {rsp_err, rsp_data}, {1'b1, 32'h0});

`ifdef JTAG_SEQ_TLR_EN
        cmd_tlr  = 1'b1;
        tdo_mode = 2'd1;
        issue(1'b1, 6'd0, 32'hFFFFFFFF);
        cmd_tlr = 1'b0;
        collect(lat, rises, seq);
        check("tlr_latency", 64'(lat), 64'd24);
        check("tlr_rises", 64'(rises), 64'd6);
        check("tlr_tms_seq", seq, 64'h1F);
        check("tlr_rsp", {rsp_err, rsp_data}, {1'b0, 32'h0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
